// File: rtl/regfile.sv
// regfile: general-purpose register file between decode and write-back.
//
// Two combinational read ports and one clocked write port. After reset
// deasserts, a clear sequencer zeroes entries 1..2**AW-1, one per cycle.
// The storage array therefore carries no reset and can map onto a plain
// memory. Entry 0 is hardwired to zero: it is never written and always
// reads as 0.
//
// Ports:
//   clk            clock, rising-edge active
//   rst            asynchronous active-low reset
//   we/waddr/wdata write-back write request (accepted only once ready)
//   re1/raddr1     read port 1 enable and address
//   rdata1         read port 1 data, combinational
//   re2/raddr2     read port 2 enable and address
//   rdata2         read port 2 data, combinational
//   ready          high once the post-reset clear has completed
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing entry clr_ptr each cycle; writes dropped, reads 0
// ST_READY | normal operation; left only through rst

module regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    output logic          ready
);

    localparam int DEPTH = 1 << AW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    logic [0:0]    state;
    logic [AW-1:0] clr_ptr;
    logic [DW-1:0] mem [DEPTH];

    // The terminal compare sits at all-ones and the pointer holds there,
    // so it never wraps back to entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= AW'(1);
        end else if (state == ST_CLEAR) begin
            if (clr_ptr == LAST_ADDR) begin
                state <= ST_READY;
            end else begin
                clr_ptr <= clr_ptr + AW'(1);
            end
        end
    end

    // Storage has no reset. While clearing, the sequencer owns the write
    // port and any write-back request is dropped.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: reset, clearing, disabled or address 0 all force zero.
    // A same-cycle write to the read address is forwarded from wdata.
    always_comb begin
        rdata1 = '0;
        if (rst && (state == ST_READY) && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = mem[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && (state == ST_READY) && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem[raddr2];
            end
        end
    end

    assign ready = (state == ST_READY);

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile (DW=32, AW=5).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.

module tb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;
    logic          ready;

    int checks = 0;
    int errors = 0;

    regfile #(.DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After rst rises: ready stays low for 30 edges and rises on the 31st.
    task automatic wait_clear(input string tag);
        for (int e = 1; e <= 31; e++) begin
            tick();
            #1;
            check($sformatf("%s_ready_e%0d", tag, e), {31'b0, ready}, (e == 31) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic read_all_zero(input string tag);
        we  = 1'b0;
        re1 = 1'b1;
        re2 = 1'b1;
        for (int i = 1; i < 32; i++) begin
            raddr1 = AW'(i);
            raddr2 = AW'(32 - i);
            #1;
            check($sformatf("%s_p1_r%0d", tag, i), rdata1, 32'h0);
            check($sformatf("%s_p2_r%0d", tag, 32 - i), rdata2, 32'h0);
            tick();
        end
    endtask

    initial begin
        rst    = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        re1    = 1'b1;
        raddr1 = 5'd5;
        re2    = 1'b1;
        raddr2 = 5'd9;
        #2 rst = 1'b0;

        // Held in reset across several edges.
        tick();
        tick();
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rdata2", rdata2, 32'h0);

        // Release reset and step through the clear, injecting two writes
        // that must be dropped: one at edge 10 and one on the edge where
        // ready rises.
        rst = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            we    = (e == 10) || (e == 31);
            waddr = (e == 10) ? 5'd3 : 5'd4;
            wdata = (e == 10) ? 32'h0000_1111 : 32'h0000_2222;
            raddr1 = 5'd3;
            #1;
            if (e == 10) check("clear_read_zero", rdata1, 32'h0);
            tick();
            #1;
            check($sformatf("init_ready_e%0d", e), {31'b0, ready}, (e == 31) ? 32'd1 : 32'd0);
        end
        we = 1'b0;
        read_all_zero("init");

        // Write r5, check bypass then storage.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = 5'd5;
        #1;
        check("r5_bypass", rdata1, 32'hDEAD_BEEF);
        check("r5_re2_off", rdata2, 32'h0);
        tick();
        we = 1'b0; wdata = 32'h0;
        #1;
        check("r5_storage", rdata1, 32'hDEAD_BEEF);

        // r0 protection.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        check("r0_same_p1", rdata1, 32'h0);
        check("r0_same_p2", rdata2, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0_next_p1", rdata1, 32'h0);
        check("r0_next_p2", rdata2, 32'h0);

        // Read enables and shared-address bypass on r7.
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        tick();
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
        #1;
        check("r7_p1_en", rdata1, 32'h1234_5678);
        check("r7_p2_dis", rdata2, 32'h0);
        re2 = 1'b1;
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
        #1;
        check("r7_byp_p1", rdata1, 32'hA5A5_A5A5);
        check("r7_byp_p2", rdata2, 32'hA5A5_A5A5);
        raddr2 = 5'd5;
        #1;
        check("r5_during_r7_wr", rdata2, 32'hDEAD_BEEF);
        tick();
        we = 1'b0;
        #1;
        check("r7_store_p1", rdata1, 32'hA5A5_A5A5);
        check("r7_store_p2", rdata2, 32'hDEAD_BEEF);

        // Fill r1..r31 with distinct nonzero values.
        re1 = 1'b1; re2 = 1'b1;
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = 32'hC000_0000 | 32'(i);
            tick();
        end
        we = 1'b0;
        raddr1 = 5'd9; raddr2 = 5'd31;
        #1;
        check("fill_r9", rdata1, 32'hC000_0009);
        check("fill_r31", rdata2, 32'hC000_001F);

        // One-cycle reset pulse mid-operation.
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 32'd0);
        check("midrst_rdata1", rdata1, 32'h0);
        check("midrst_rdata2", rdata2, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        check("reclear_rdata1", rdata1, 32'h0);
        wait_clear("reclr");
        read_all_zero("reclr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
